// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encoding and counter sizing shared by the serial adder.
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fa_cell.sv
// fa_cell: 1-bit full adder, one link of the serial adder's ripple chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ c;
  assign cout = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial a+b+cin, BPC bits per clock; SERIAL_ADDER_SUB_EN adds a sub port for a-b.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int N  = WIDTH / BPC;
  localparam int CW = cnt_width(N);
  if (WIDTH < 2 || WIDTH % BPC != 0) begin : g_chk
    $error("serial_adder: BPC must divide WIDTH and WIDTH must be >= 2");
  end
  state_t           state;
  logic [WIDTH-1:0] ra, rb, rs, nxt;
  logic             carry, b_inv, c0;
  logic [CW-1:0]    cnt;
  logic [BPC:0]     c;
  logic [BPC-1:0]   s;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_inv = sub;
  assign c0    = sub | cin;
`else
  assign b_inv = 1'b0;
  assign c0    = cin;
`endif
  assign c[0] = carry;
  for (genvar i = 0; i < BPC; i++) begin : g_fa
    fa_cell u_fa (.a(ra[i]), .b(rb[i]), .c(c[i]), .s(s[i]), .cout(c[i+1]));
  end
  // new digit enters at the MSB end, so after N steps the sum is aligned
  assign nxt = WIDTH'({s, rs} >> BPC);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      ra        <= '0;
      rb        <= '0;
      rs        <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          ra       <= a;
          rb       <= b_inv ? ~b : b;
          carry    <= c0;
          cnt      <= '0;
          in_ready <= 1'b0;
          state    <= RUN;
        end
        RUN: begin
          ra    <= ra >> BPC;
          rb    <= rb >> BPC;
          rs    <= nxt;
          carry <= c[BPC];
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            sum       <= nxt;
            cout      <= c[BPC];
            overflow  <= c[BPC] ^ c[BPC-1];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised digit-serial adder. It is the sequential successor to the single-bit full adder.
- Accepts two WIDTH-bit operands plus a carry-in through a valid/ready handshake.
- Adds BPC bits per clock through a chain of full-adder cells, then presents sum, carry-out and signed overflow through a second valid/ready handshake.
- Used where area matters more than latency, e.g. accumulators and checksum units in the combinational-circuits library.

Parameters:
- WIDTH, 8, operand and sum width in bits (>=2).
- BPC, 1, bits processed per cycle. Must divide WIDTH. Elaboration error otherwise.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  a+b+cin, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Interface: one clock `clk`. Reset `rst_n` is synchronous and active-low: it is sampled only on the rising edge of `clk`, and asserting it (low) resets the block.
- Constants: N = WIDTH/BPC (digit count). FSM states are IDLE, RUN, DONE.
- Reset (rst_n=0 at an edge): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, overflow=0. Internal shift registers, digit counter and carry flop are cleared.
- Reset mid-RUN or mid-DONE aborts the operation. The result is discarded and never presented.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a, b, cin; counter=0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge adds the low BPC bits of the A/B shift registers plus the carry flop.
  - The BPC result bits shift into the MSB end of the sum register. A and B shift right by BPC. The carry flop takes the chain carry-out.
  - The counter increments each edge.
  - On the edge where counter==N-1: capture cout, compute overflow from the MSB cell's carry-in and carry-out, go to DONE.
- DONE:
  - out_valid=1. sum, cout and overflow are stable.
  - On an edge with out_ready=1: go to IDLE, out_valid=0.
  - out_ready=0 holds DONE indefinitely with outputs unchanged.
- Latency: if operands are accepted at edge k, out_valid is high after edge k+N.
- Throughput: one operation per N+2 cycles at best. No overlap of input acceptance with DONE.
- Outputs sum, cout and overflow keep their last values in IDLE and RUN. They change only on the transition into DONE or on reset.
- in_valid is ignored outside IDLE. Operand inputs are don't-care except at the accept edge.
- Boundaries:
  - All-ones + 1 wraps to 0 with cout=1.
  - cin=1 with a=b=0 gives sum=1.
  - BPC=WIDTH gives N=1, a single RUN cycle.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- When defined: adds input port sub (1 bit), sampled at the accept edge.
  - sub=1: B is latched inverted and the effective carry-in is 1, ignoring cin. The result is a-b. cout=1 means no borrow. overflow is the signed subtraction overflow.
  - sub=0: behaves as plain addition.
- When undefined: no sub port; add only.

Decomposition:
- Package serial_adder_pkg holds:
  - the FSM state enum (IDLE, RUN, DONE), 2-bit encoding;
  - a function computing the counter width, $clog2(N) with a minimum of 1.
- One natural sub-module: fa_cell, a 1-bit full adder (a, b, c -> s, cout). It is instantiated BPC times as a ripple chain inside the RUN datapath.

Test Plan:
- WIDTH=8, BPC=1: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, overflow=0; out_valid high exactly 8 edges after accept.
- WIDTH=8, BPC=1: a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, overflow=1. Then a=8'h80, b=8'h80 -> sum=8'h00, cout=1, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0 throughout. Raise out_ready -> in_ready=1 next cycle. in_valid pulsed during RUN -> ignored.
- Reset mid-RUN (rst_n=0 at the 3rd RUN edge) -> next cycle state IDLE, in_ready=1, out_valid=0, sum=0; a new operation 8'h12+8'h34 then yields 8'h46.
- WIDTH=8, BPC=4: a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1, out_valid 2 edges after accept. WIDTH=8, BPC=8 -> 1 edge.
- With SERIAL_ADDER_SUB_EN defined: a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, cout=0, overflow=0. a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, cout=1, overflow=1.
